// File: rtl/ram_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the RAM controller and its load counter.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN     = 2'd0;
  localparam state_t ST_QUIESCE = 2'd1;
  localparam state_t ST_LOAD    = 2'd2;
  localparam state_t ST_FINISH  = 2'd3;

endpackage

// File: rtl/ram_ld_counter.sv
// Program-load address counter: synchronous clear, increment on enable,
// wrap flag raised while the counter sits on the last RAM address.
module ram_ld_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = &cnt_q;

endmodule

// File: rtl/ram_ctrl.sv
// RAM access arbiter between the CPU bus and a byte-stream program loader.
// The CPU is halted while the loader owns the RAM.
//
// state   | meaning
// RUN     | CPU passthrough to RAM, MAR loadable
// QUIESCE | one-cycle drain: CPU halted, no RAM access, counter cleared
// LOAD    | loader bytes written at the load counter
// FINISH  | one-cycle ld_done pulse, MAR cleared, then back to RUN
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mi,
  input  logic              cpu_ri,
  input  logic              cpu_ro,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_start,
  input  logic              ld_last,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ram_ri,
  output logic              ram_ro,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_halt,
  output logic              ld_done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] ld_cnt;
  logic              ld_wrap;
  logic              cnt_clr, cnt_en;

  ram_ld_counter #(.W(ADDR_W)) u_ld_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (ld_cnt),
    .wrap_o (ld_wrap)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cpu_mi)   mar_d   = bus_in[ADDR_W-1:0];
        if (ld_start) state_d = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        cnt_clr = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_valid) begin
          cnt_en = 1'b1;
          // Final byte is either flagged by the loader or lands on the last address.
          if (ld_last || ld_wrap) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        mar_d   = '0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      mar_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
    end
  end

  always_comb begin
    mem_address = mar_q;
    ram_ri      = 1'b0;
    ram_ro      = 1'b0;
    ram_wdata   = bus_in;
    ld_ready    = 1'b0;
    cpu_halt    = 1'b1;
    ld_done     = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Gate with reset so a CPU strobe cannot reach the RAM while reset is held.
        ram_ri   = cpu_ri & rst_n;
        ram_ro   = cpu_ro & rst_n;
        cpu_halt = 1'b0;
      end
      ST_LOAD: begin
        mem_address = ld_cnt;
        ram_wdata   = ld_data;
        ram_ri      = ld_valid;
        ld_ready    = 1'b1;
      end
      ST_FINISH: ld_done = 1'b1;
      default: ;
    endcase
  end

endmodule
